// File: rtl/rv32_wb_arbiter_if.sv
// Writeback arbiter bus: per-channel writeback request channels plus the
// single register-file write port.
interface rv32_wb_arbiter_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]    in_valid;
  logic [NUM_PORTS-1:0]    in_ready;
  logic [NUM_PORTS*5-1:0]  in_rd;
  logic [NUM_PORTS*32-1:0] in_data;
  logic [NUM_PORTS-1:0]    in_is_load;
  logic [NUM_PORTS*3-1:0]  in_mem_op;
  logic [NUM_PORTS*2-1:0]  in_addr_lo;
  logic                    reg_write;
  logic [4:0]              rd;
  logic [31:0]             wb_data;
  logic                    busy;

  modport master (
    output in_valid, in_rd, in_data, in_is_load, in_mem_op, in_addr_lo,
    input  in_ready, reg_write, rd, wb_data, busy
  );

  modport slave (
    input  in_valid, in_rd, in_data, in_is_load, in_mem_op, in_addr_lo,
    output in_ready, reg_write, rd, wb_data, busy
  );
endinterface

// File: rtl/rv32_wb_arbiter.sv
// Round-robin writeback arbiter: per-channel FIFOs feeding one register-file
// write port, with load byte/halfword extraction applied on the way out.
module rv32_wb_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int QUEUE_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  rv32_wb_arbiter_if.slave bus
);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int AW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        is_load;
    logic [2:0]  mem_op;
    logic [1:0]  addr_lo;
  } entry_t;

  entry_t               mem    [NUM_PORTS][QUEUE_DEPTH];
  logic [PW-1:0]        wr_ptr [NUM_PORTS];
  logic [PW-1:0]        rd_ptr [NUM_PORTS];
  logic [CW-1:0]        count  [NUM_PORTS];
  logic [AW-1:0]        rr_ptr;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] nonempty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic                 grant_vld;
  logic [AW-1:0]        grant_idx;
  entry_t               head;
  logic [31:0]          fixed;
  logic                 reg_write_q;
  logic [4:0]           rd_q;
  logic [31:0]          wb_data_q;

  function automatic logic [PW-1:0] q_next(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [AW-1:0] port_next(input logic [AW-1:0] p);
    return (p == AW'(NUM_PORTS - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      full[i]     = (count[i] == CW'(QUEUE_DEPTH));
      nonempty[i] = (count[i] != '0);
    end
  end

  // Ready depends only on registered occupancy; rst forces it low while held.
  assign bus.in_ready = ~full & {NUM_PORTS{~rst}};
  assign push         = bus.in_valid & bus.in_ready;

  always_comb begin
    logic [AW-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    idx       = rr_ptr;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!grant_vld && nonempty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
      idx = port_next(idx);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++)
      pop[i] = grant_vld && (grant_idx == AW'(i));
  end

  assign head = mem[grant_idx][rd_ptr[grant_idx]];

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b     = 8'(head.data >> {head.addr_lo, 3'b000});
    h     = 16'(head.data >> {head.addr_lo[1], 4'b0000});
    fixed = head.data;
    if (head.is_load) begin
      case (head.mem_op)
        3'b000:  fixed = {{24{b[7]}}, b};
        3'b100:  fixed = {24'h0, b};
        3'b001:  fixed = {{16{h[15]}}, h};
        3'b101:  fixed = {16'h0, h};
        default: fixed = head.data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (push[i])
        mem[i][wr_ptr[i]] <= '{rd:      bus.in_rd[5*i +: 5],
                               data:    bus.in_data[32*i +: 32],
                               is_load: bus.in_is_load[i],
                               mem_op:  bus.in_mem_op[3*i +: 3],
                               addr_lo: bus.in_addr_lo[2*i +: 2]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr      <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wb_data_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (push[i]) wr_ptr[i] <= q_next(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= q_next(rd_ptr[i]);
        if (push[i] && !pop[i])
          count[i] <= count[i] + CW'(1);
        else if (pop[i] && !push[i])
          count[i] <= count[i] - CW'(1);
      end
      if (grant_vld) begin
        rr_ptr      <= port_next(grant_idx);
        reg_write_q <= (head.rd != 5'd0);
        rd_q        <= head.rd;
        wb_data_q   <= fixed;
      end else begin
        reg_write_q <= 1'b0;
      end
    end
  end

  assign bus.reg_write = reg_write_q;
  assign bus.rd        = rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.busy      = (|nonempty) | reg_write_q;
endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Directed bench for rv32_wb_arbiter: table of single writebacks plus
// hand-traced contention/backpressure and mid-flight reset sequences.
module tb_rv32_wb_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  rv32_wb_arbiter_if #(.NUM_PORTS(2)) bus ();

  rv32_wb_arbiter #(.NUM_PORTS(2), .QUEUE_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          port;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        is_load;
    logic [2:0]  mem_op;
    logic [1:0]  addr_lo;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid   = '0;
    bus.in_rd      = '0;
    bus.in_data    = '0;
    bus.in_is_load = '0;
    bus.in_mem_op  = '0;
    bus.in_addr_lo = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] D = 32'h80FF7F01;

  logic [31:0] c_data [1:10];
  logic [4:0]  c_rd   [1:10];
  logic        c_we   [1:10];
  logic [1:0]  c_rdy  [1:10];

  initial begin
    int ia;
    int ib;
    int ghost;
    logic [1:0] acc;

    tests = 0;
    fails = 0;
    rst   = 1'b1;
    idle();

    // port, rd, data, is_load, mem_op, addr_lo, exp_we, exp_data
    vq.push_back('{0, 5'd5,  32'h12345678, 1'b0, 3'b000, 2'd0, 1'b1, 32'h12345678});
    vq.push_back('{0, 5'd6,  D,            1'b1, 3'b000, 2'd3, 1'b1, 32'hFFFFFF80});
    vq.push_back('{0, 5'd7,  D,            1'b1, 3'b100, 2'd1, 1'b1, 32'h0000007F});
    vq.push_back('{0, 5'd8,  D,            1'b1, 3'b001, 2'd2, 1'b1, 32'hFFFF80FF});
    vq.push_back('{0, 5'd9,  D,            1'b1, 3'b101, 2'd3, 1'b1, 32'h000080FF});
    vq.push_back('{1, 5'd10, D,            1'b1, 3'b010, 2'd1, 1'b1, D});
    vq.push_back('{1, 5'd11, D,            1'b1, 3'b000, 2'd0, 1'b1, 32'h00000001});
    vq.push_back('{1, 5'd12, D,            1'b1, 3'b000, 2'd2, 1'b1, 32'hFFFFFFFF});
    vq.push_back('{1, 5'd13, D,            1'b1, 3'b001, 2'd0, 1'b1, 32'h00007F01});
    vq.push_back('{0, 5'd14, D,            1'b1, 3'b101, 2'd1, 1'b1, 32'h00007F01});
    vq.push_back('{0, 5'd15, D,            1'b1, 3'b011, 2'd2, 1'b1, D});
    vq.push_back('{1, 5'd16, D,            1'b1, 3'b110, 2'd0, 1'b1, D});
    vq.push_back('{1, 5'd17, D,            1'b1, 3'b111, 2'd3, 1'b1, D});
    vq.push_back('{0, 5'd18, D,            1'b0, 3'b000, 2'd3, 1'b1, D});
    vq.push_back('{1, 5'd0,  32'hDEADBEEF, 1'b0, 3'b000, 2'd0, 1'b0, 32'h0});
    vq.push_back('{1, 5'd31, D,            1'b1, 3'b100, 2'd2, 1'b1, 32'h000000FF});

    // Contention trace: grants alternate, port 1 backpressured after 2 accepts.
    c_we  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    c_rd  = '{5'd0, 5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12, 5'd0};
    c_data = '{32'h0, 32'hA0000000, 32'hB0000000, 32'hA0000001, 32'hB0000001,
               32'hA0000002, 32'hB0000002, 32'hA0000003, 32'hB0000003, 32'h0};
    c_rdy = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};

    #2;
    check("rst_ready",     32'(bus.in_ready),  32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    check("rst_reg_write", 32'(bus.reg_write), 32'h0);
    check("rst_rd",        32'(bus.rd),        32'h0);
    check("rst_wb_data",   bus.wb_data,        32'h0);
    step();
    step();
    check("rst_held_ready", 32'(bus.in_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'h3);

    foreach (vq[n]) begin
      idle();
      bus.in_valid[vq[n].port]            = 1'b1;
      bus.in_rd[5*vq[n].port +: 5]        = vq[n].rd;
      bus.in_data[32*vq[n].port +: 32]    = vq[n].data;
      bus.in_is_load[vq[n].port]          = vq[n].is_load;
      bus.in_mem_op[3*vq[n].port +: 3]    = vq[n].mem_op;
      bus.in_addr_lo[2*vq[n].port +: 2]   = vq[n].addr_lo;
      step();
      idle();
      check($sformatf("vec%0d_no_same_cycle", n), 32'(bus.reg_write), 32'h0);
      check($sformatf("vec%0d_busy_queued", n),   32'(bus.busy),      32'h1);
      step();
      check($sformatf("vec%0d_we", n), 32'(bus.reg_write), 32'(vq[n].exp_we));
      if (vq[n].exp_we) begin
        check($sformatf("vec%0d_rd", n),   32'(bus.rd), 32'(vq[n].rd));
        check($sformatf("vec%0d_data", n), bus.wb_data, vq[n].exp_data);
      end
      step();
      check($sformatf("vec%0d_we_drop", n), 32'(bus.reg_write), 32'h0);
      check($sformatf("vec%0d_idle", n),    32'(bus.busy),      32'h0);
    end

    ia = 0;
    ib = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      bus.in_valid = {ib < 4, ia < 4};
      bus.in_rd    = {5'(9 + ib), 5'(1 + ia)};
      bus.in_data  = {32'hB0000000 + 32'(ib), 32'hA0000000 + 32'(ia)};
      acc = bus.in_valid & bus.in_ready;
      step();
      if (acc[0]) ia++;
      if (acc[1]) ib++;
      check($sformatf("cont%0d_we", cyc),    32'(bus.reg_write), 32'(c_we[cyc]));
      check($sformatf("cont%0d_ready", cyc), 32'(bus.in_ready),  32'(c_rdy[cyc]));
      if (c_we[cyc]) begin
        check($sformatf("cont%0d_rd", cyc),   32'(bus.rd), 32'(c_rd[cyc]));
        check($sformatf("cont%0d_data", cyc), bus.wb_data, c_data[cyc]);
      end
    end
    idle();
    check("cont_busy_end", 32'(bus.busy), 32'h0);

    bus.in_valid = 2'b11;
    bus.in_rd    = {5'd20, 5'd21};
    bus.in_data  = {32'hCAFE0001, 32'hCAFE0000};
    step();
    check("mid_busy_before", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    idle();
    #1;
    check("mid_rst_busy",  32'(bus.busy),      32'h0);
    check("mid_rst_we",    32'(bus.reg_write), 32'h0);
    check("mid_rst_ready", 32'(bus.in_ready),  32'h0);
    step();
    rst = 1'b0;
    #1;
    check("mid_post_ready", 32'(bus.in_ready), 32'h3);
    ghost = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      if (bus.reg_write !== 1'b0 || bus.busy !== 1'b0) ghost++;
    end
    check("mid_no_ghost_write", 32'(ghost), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
